// File: rtl/gol_pkg.sv
// Shared Game of Life display definitions: grid geometry, scanner FSM
// states and a helper that pulls one row of cells out of a packed grid.
package gol_pkg;

    localparam int GRID_W    = 8;
    localparam int GRID_H    = 8;
    localparam int GRID_BITS = GRID_W * GRID_H;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        BLANK = 2'd2
    } scan_state_t;

    // Cell (r,c) lives at bit 8*r+c, so row r is the byte starting at 8*r.
    function automatic logic [GRID_W-1:0] row_bits(
        input logic [GRID_BITS-1:0] grid,
        input logic [2:0]           row
    );
        return grid[{row, 3'b000} +: GRID_W];
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Dwell counter shared by the row-lit interval and the blank interval.
// The count restarts from zero whenever load is high; expired flags the
// cycle on which the count equals limit, so an interval of N cycles uses
// limit = N-1 and asserts load on the expiring cycle to start the next one.
module scan_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: restart on load, otherwise advance by one.
    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (load) begin
            cnt_d = '0;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == limit);

endmodule

// File: rtl/led_matrix_scanner.sv
// Row-scanning driver for an 8x8 LED matrix fed with Game of Life grids.
//
// A frame arrives over a valid/ready handshake. Handshake rule: a transfer
// happens on every rising clk edge where frame_valid && frame_ready; the
// producer must hold frame and frame_valid stable until that edge, and
// frame_valid while frame_ready is low is simply not taken.
//
// The first frame after reset goes straight into the active buffer and the
// scan starts on row 0 the next cycle. Later frames land in a shadow buffer
// and are swapped in only at the frame boundary (last cycle of row 7), so a
// displayed frame never tears. The scan never returns to IDLE except through
// reset.
//
// Build option: define SCAN_BLANK_EN to insert BLANK_CYCLES dark cycles
// after every row (including row 7); the frame boundary then falls on the
// last dark cycle after row 7. Without it rows are back-to-back and
// BLANK_CYCLES only sizes the shared counter.
module led_matrix_scanner
    import gol_pkg::*;
#(
    parameter int CYCLES_PER_ROW = 1000,
    parameter int BLANK_CYCLES   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [GRID_BITS-1:0] frame,
    input  logic                 frame_valid,
    output logic                 frame_ready,
    output logic [GRID_W-1:0]    row_sel,
    output logic [GRID_W-1:0]    col_data,
    output logic                 frame_done,
    output scan_state_t          state_dbg
);

    localparam int MAX_DWELL = (CYCLES_PER_ROW > BLANK_CYCLES) ? CYCLES_PER_ROW : BLANK_CYCLES;
    localparam int CNT_W     = (MAX_DWELL <= 2) ? 1 : $clog2(MAX_DWELL);

    localparam logic [CNT_W-1:0] ROW_LIMIT   = CNT_W'(CYCLES_PER_ROW - 1);
`ifdef SCAN_BLANK_EN
    localparam logic [CNT_W-1:0] BLANK_LIMIT = CNT_W'(BLANK_CYCLES - 1);
`endif

    scan_state_t            state_q, state_d;
    logic [2:0]             row_q, row_d;
    logic [GRID_BITS-1:0]   active_q, active_d;
    logic [GRID_BITS-1:0]   shadow_q, shadow_d;
    logic                   shadow_full_q, shadow_full_d;
    logic [GRID_W-1:0]      row_sel_q, row_sel_d;
    logic [GRID_W-1:0]      col_data_q, col_data_d;

    logic                   handshake;
    logic                   boundary;
    logic                   timer_load;
    logic [CNT_W-1:0]       timer_limit;
    logic                   dwell_expired;

    // The shadow is empty whenever we are idle, so ready there is just reset.
    assign frame_ready = reset && !shadow_full_q;
    assign handshake   = frame_valid && frame_ready;

    scan_timer #(
        .W (CNT_W)
    ) u_dwell (
        .clk     (clk),
        .reset   (reset),
        .load    (timer_load),
        .limit   (timer_limit),
        .expired (dwell_expired)
    );

    // Next-state logic: FSM, row index, buffers and registered display data.
    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        active_d      = active_q;
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        timer_load    = 1'b1;
        timer_limit   = ROW_LIMIT;
        boundary      = 1'b0;

        case (state_q)
            IDLE: begin
                if (handshake) begin
                    active_d = frame;
                    state_d  = SCAN;
                    row_d    = 3'd0;
                end
            end
            SCAN: begin
                timer_load = dwell_expired;
                if (dwell_expired) begin
`ifdef SCAN_BLANK_EN
                    state_d = BLANK;
`else
                    row_d = row_q + 3'd1;
                    if (row_q == 3'd7) begin
                        boundary = 1'b1;
                    end
`endif
                end
            end
`ifdef SCAN_BLANK_EN
            BLANK: begin
                timer_limit = BLANK_LIMIT;
                timer_load  = dwell_expired;
                if (dwell_expired) begin
                    state_d = SCAN;
                    row_d   = row_q + 3'd1;
                    if (row_q == 3'd7) begin
                        boundary = 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        // While scanning, accepted frames wait in the shadow buffer.
        if (state_q != IDLE && handshake) begin
            shadow_d      = frame;
            shadow_full_d = 1'b1;
        end

        // Swap only at the boundary; a handshake on the same cycle can only
        // happen with the shadow empty, so the two never collide.
        if (boundary && shadow_full_q) begin
            active_d      = shadow_q;
            shadow_full_d = 1'b0;
        end

        row_sel_d  = '0;
        col_data_d = '0;
        if (state_d == SCAN) begin
            row_sel_d  = GRID_W'(1) << row_d;
            col_data_d = row_bits(active_d, row_d);
        end
    end

    // State and buffer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            row_q         <= 3'd0;
            active_q      <= '0;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            row_sel_q     <= '0;
            col_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            active_q      <= active_d;
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
            row_sel_q     <= row_sel_d;
            col_data_q    <= col_data_d;
        end
    end

    assign row_sel    = row_sel_q;
    assign col_data   = col_data_q;
    assign frame_done = reset && boundary;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Self-checking bench for led_matrix_scanner with CYCLES_PER_ROW=4 and
// BLANK_CYCLES=2. Honours SCAN_BLANK_EN when the build defines it.
module tb_led_matrix_scanner;
    import gol_pkg::*;

    localparam int CPR = 4;
    localparam int BLK = 2;
`ifdef SCAN_BLANK_EN
    localparam int PER_ROW = CPR + BLK;
`else
    localparam int PER_ROW = CPR;
`endif
    localparam int PERIOD = 8 * PER_ROW;

    logic        clk;
    logic        reset;
    logic [63:0] frame;
    logic        frame_valid;
    logic        frame_ready;
    logic [7:0]  row_sel;
    logic [7:0]  col_data;
    logic        frame_done;
    scan_state_t state_dbg;

    int checks   = 0;
    int failures = 0;
    logic sfull_m;

    typedef struct packed {
        logic [63:0]     frame;
        logic [7:0][7:0] exp_cols;
    } vec_t;

    vec_t vecs[5];

    led_matrix_scanner #(
        .CYCLES_PER_ROW (CPR),
        .BLANK_CYCLES   (BLK)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame       (frame),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .row_sel     (row_sel),
        .col_data    (col_data),
        .frame_done  (frame_done),
        .state_dbg   (state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Hold reset low for n cycles with a frame offered, checking dark outputs.
    task automatic do_reset(input int n);
        reset       = 1'b0;
        frame       = 64'hDEAD_BEEF_CAFE_F00D;
        frame_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            check($sformatf("rst row_sel c%0d", i), 64'(row_sel), 64'h0);
            check($sformatf("rst col_data c%0d", i), 64'(col_data), 64'h0);
            check($sformatf("rst ready c%0d", i), 64'(frame_ready), 64'h0);
            check($sformatf("rst done c%0d", i), 64'(frame_done), 64'h0);
            check($sformatf("rst state c%0d", i), 64'(state_dbg), 64'(IDLE));
        end
        frame_valid = 1'b0;
        reset       = 1'b1;
        sfull_m     = 1'b0;
        #1;
        check("rst release ready", 64'(frame_ready), 64'h1);
    endtask

    // Handshake a frame in IDLE; returns at the first cycle of row 0.
    task automatic load_idle(input logic [63:0] f, input string tag);
        check({tag, " idle state"}, 64'(state_dbg), 64'(IDLE));
        check({tag, " idle dark"}, 64'(row_sel), 64'h0);
        frame       = f;
        frame_valid = 1'b1;
        check({tag, " idle ready"}, 64'(frame_ready), 64'h1);
        tick();
        frame_valid = 1'b0;
        check({tag, " scan state"}, 64'(state_dbg), 64'(SCAN));
    endtask

    // Walk one full frame period checking every cycle. Optional offers are
    // raised at slots offer_a/offer_b and held until the model accepts them.
    task automatic walk_frame(input logic [7:0][7:0] exp_cols,
                              input int offer_a, input logic [63:0] frame_a,
                              input int offer_b, input logic [63:0] frame_b,
                              input string tag);
        int   r;
        int   w;
        logic lit;
        logic bnd;
        logic hs;
        logic [7:0] exp_rs;
        logic [7:0] exp_col;
        for (int s = 0; s < PERIOD; s++) begin
            r       = s / PER_ROW;
            w       = s % PER_ROW;
            lit     = (w < CPR);
            bnd     = (s == PERIOD - 1);
            exp_rs  = lit ? (8'h01 << r) : 8'h00;
            exp_col = lit ? exp_cols[r] : 8'h00;
            if (s == offer_a) begin
                frame       = frame_a;
                frame_valid = 1'b1;
            end
            if (s == offer_b) begin
                frame       = frame_b;
                frame_valid = 1'b1;
            end
            check($sformatf("%s row_sel s%0d", tag, s), 64'(row_sel), 64'(exp_rs));
            check($sformatf("%s col_data s%0d", tag, s), 64'(col_data), 64'(exp_col));
            check($sformatf("%s done s%0d", tag, s), 64'(frame_done), 64'(bnd));
            check($sformatf("%s ready s%0d", tag, s), 64'(frame_ready), 64'(!sfull_m));
            hs = frame_valid && !sfull_m;
            tick();
            if (bnd && sfull_m) begin
                sfull_m = 1'b0;
            end
            if (hs) begin
                sfull_m     = 1'b1;
                frame_valid = 1'b0;
            end
        end
    endtask

    localparam logic [63:0] FR_A = 64'h0000_0000_0000_00FF;
    localparam logic [63:0] FR_B = 64'hFF00_0000_0000_0000;
    localparam logic [63:0] FR_C = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] FR_D = 64'h8040_2010_0804_0201;
    localparam logic [63:0] FR_E = 64'hAA55_0FF0_3CC3_817E;

    localparam logic [7:0][7:0] COLS_A = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
    localparam logic [7:0][7:0] COLS_B = {8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    localparam logic [7:0][7:0] COLS_C = {8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    localparam logic [7:0][7:0] COLS_D = {8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    localparam logic [7:0][7:0] COLS_E = {8'hAA, 8'h55, 8'h0F, 8'hF0, 8'h3C, 8'hC3, 8'h81, 8'h7E};

    initial begin
        reset       = 1'b0;
        frame       = '0;
        frame_valid = 1'b0;
        sfull_m     = 1'b0;

        vecs[0] = '{frame: FR_D, exp_cols: COLS_D};
        vecs[1] = '{frame: FR_A, exp_cols: COLS_A};
        vecs[2] = '{frame: FR_B, exp_cols: COLS_B};
        vecs[3] = '{frame: FR_C, exp_cols: COLS_C};
        vecs[4] = '{frame: FR_E, exp_cols: COLS_E};

        // Reset held with frame_valid high, then released.
        do_reset(3);

        // Table: load each pattern from IDLE, scan it, then check it rescans unchanged.
        for (int v = 0; v < 5; v++) begin
            if (v != 0) do_reset(2);
            load_idle(vecs[v].frame, $sformatf("vec%0d", v));
            walk_frame(vecs[v].exp_cols, -1, '0, -1, '0, $sformatf("vec%0d f0", v));
            walk_frame(vecs[v].exp_cols, -1, '0, -1, '0, $sformatf("vec%0d f1", v));
        end

        // B offered mid row 3, C offered in row 5 while B waits in shadow.
        do_reset(2);
        load_idle(FR_A, "swap");
        walk_frame(COLS_A, 3 * PER_ROW + 1, FR_B, 5 * PER_ROW, FR_C, "swap fA");
        check("swap C still pending", 64'(frame_valid), 64'h1);
        walk_frame(COLS_B, -1, '0, -1, '0, "swap fB");
        walk_frame(COLS_C, -1, '0, -1, '0, "swap fC");
        walk_frame(COLS_C, -1, '0, -1, '0, "swap fC2");

        // Offer on the boundary cycle with shadow empty: no bypass.
        do_reset(2);
        load_idle(FR_D, "bnd");
        walk_frame(COLS_D, PERIOD - 1, FR_E, -1, '0, "bnd fD");
        walk_frame(COLS_D, -1, '0, -1, '0, "bnd fD2");
        walk_frame(COLS_E, -1, '0, -1, '0, "bnd fE");

        // Reset during row 5 with a frame parked in shadow.
        do_reset(2);
        load_idle(FR_C, "mid");
        for (int s = 0; s < 5 * PER_ROW + 2; s++) begin
            if (s == 2 * PER_ROW) begin
                frame       = FR_B;
                frame_valid = 1'b1;
            end else begin
                frame_valid = 1'b0;
            end
            tick();
        end
        check("mid row5 row_sel", 64'(row_sel), 64'h20);
        check("mid row5 col_data", 64'(col_data), 64'h45);
        check("mid shadow full ready", 64'(frame_ready), 64'h0);
        reset = 1'b0;
        tick();
        check("mid rst row_sel", 64'(row_sel), 64'h0);
        check("mid rst col_data", 64'(col_data), 64'h0);
        check("mid rst done", 64'(frame_done), 64'h0);
        check("mid rst state", 64'(state_dbg), 64'(IDLE));
        reset   = 1'b1;
        sfull_m = 1'b0;
        #1;
        check("mid release ready", 64'(frame_ready), 64'h1);
        load_idle(FR_D, "mid");
        walk_frame(COLS_D, -1, '0, -1, '0, "mid fD");
        walk_frame(COLS_D, -1, '0, -1, '0, "mid fD2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_matrix_scanner.md
Name: led_matrix_scanner

Overview:
- Consumes the 64-bit Game of Life grid produced by the evolution FSM and drives an 8x8 LED matrix by time-multiplexed row scanning.
- Accepts grid frames through a valid/ready handshake into a shadow register.
- Swaps a new frame into the active buffer only at frame boundaries, so a displayed frame never tears.
- Sits between the evolution FSM's display output and the board's row/column driver pins.

Parameters:
- CYCLES_PER_ROW, 1000: clock cycles each row is lit. Legal minimum is 2.
- BLANK_CYCLES, 4: dark cycles inserted between rows. Used only when SCAN_BLANK_EN is defined. Legal minimum is 1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset.
- frame  in  64  grid; cell (r,c) is bit 8*r+c, r=row 0..7, c=column 0..7.
- frame_valid  in  1  frame holds a new grid.
- frame_ready  out  1  block can accept a frame this cycle.
- row_sel  out  8  one-hot active-high row enable; all zeros means dark.
- col_data  out  8  column data for the selected row; bit c equals cell (r,c).
- frame_done  out  1  one-cycle pulse at the end of each full 8-row scan.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, row index=0, dwell counter=0.
  - Active buffer=0, shadow buffer=0, shadow_full=0.
  - Outputs: row_sel=0, col_data=0, frame_done=0, frame_ready=0 while reset is asserted.
  - Reset mid-scan abandons the frame immediately; no frame_done pulse.
- frame_ready = reset high AND NOT shadow_full (in IDLE it is 1, since shadow is unused there). Handshake occurs when frame_valid && frame_ready at a clk edge.
- IDLE:
  - Outputs dark.
  - On handshake: frame goes directly into the active buffer; next state is SCAN, row 0, counter 0.
- SCAN:
  - row_sel = 1<<row; col_data = active[8*row+7 : 8*row]. Both are registered and update on the cycle the state/row changes.
  - Counter increments each cycle. At CYCLES_PER_ROW-1 the counter clears and the row advances.
  - Each row is lit for exactly CYCLES_PER_ROW cycles.
- SCAN handshake: frame goes into the shadow buffer; shadow_full=1. frame_ready drops the next cycle.
- Frame boundary (last cycle of row 7):
  - frame_done=1 for that single cycle.
  - If shadow_full: active<=shadow and shadow_full<=0. frame_ready returns to 1 the next cycle.
  - Otherwise the active frame is rescanned unchanged.
  - Row wraps 7->0.
- Simultaneous handshake and boundary with shadow empty: the frame is captured into shadow only. It is displayed from the next boundary; there is no bypass.
- frame_valid while frame_ready=0 is ignored. The producer must hold it.
- No return to IDLE except by reset.
- Latency: first frame lit on row 0 one cycle after its handshake in IDLE. Later frames appear at the first boundary after acceptance.

Optional Feature:
- Macro: SCAN_BLANK_EN.
- Defined:
  - A BLANK state follows each row's dwell, including row 7.
  - In BLANK, row_sel=0 and col_data=0 for BLANK_CYCLES cycles, then the next row is lit.
  - The frame boundary (frame_done, swap, wrap) is evaluated on the last BLANK cycle after row 7.
  - Frame period = 8*(CYCLES_PER_ROW+BLANK_CYCLES).
- Undefined:
  - No BLANK state; the BLANK_CYCLES parameter is unused.
  - Rows are back-to-back; frame period = 8*CYCLES_PER_ROW.

Decomposition:
- Package gol_pkg:
  - GRID_W=8, GRID_H=8, GRID_BITS=64.
  - Enum scan_state_t {IDLE, SCAN, BLANK}.
  - Row-extract helper function taking (grid, row).
- Sub-module scan_timer:
  - Parameterised dwell counter with clk, reset, load, limit and expired outputs.
  - Reused for both the row dwell and the blank interval.

Test Plan (CYCLES_PER_ROW=4, BLANK_CYCLES=2):
1. Reset held 3 cycles, frame_valid=1 -> row_sel=0, col_data=0, frame_ready=0 throughout. Release -> frame_ready=1.
2. IDLE handshake with frame=64'h8040201008040201 -> row_sel=01/col_data=01 for 4 cycles, then 02/02 … 80/80. frame_done pulses on cycle 32 after the handshake.
3. During scan of frame A=64'hFF, offer B=64'hFF00000000000000 mid row 3 -> frame_ready low next cycle. Rows 4-7 still show A (zeros). After the boundary, row 0 shows 00 and row 7 shows FF.
4. Second offer C while shadow holds B -> not accepted, frame_ready stays 0. C is accepted the cycle after the boundary and is displayed one frame later.
5. Reset asserted during row 5 -> next cycle outputs dark and state IDLE. No frame_done pulse. Active buffer reads 0 after re-entry.
6. With SCAN_BLANK_EN: row 0 lit 4 cycles, then row_sel=0 for 2 cycles, then row 1 -> frame_done period = 48 cycles.
